mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback stage. Sits directly downstream of the data-memory stage and feeds the register-file write port.
- Captures the ALU result, load data, destination register and control from the memory stage. Aligns and extends sub-word loads, then selects the writeback value.
- Drives the register-file write and a forwarding tap, with a valid/ready handshake, flush, and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- RET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  kill the held entry and any incoming entry.
- aluout  in  XLEN  ALU result / memory address.
- read_data  in  XLEN  raw word from data memory.
- pc_plus4  in  XLEN  link value for jal/jalr.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- wb_sel  in  2  00 ALU, 01 memory, 10 pc_plus4, 11 reserved (treated as ALU).
- load_f3  in  3  load funct3.
- rf_ready  in  1  register-file write port free this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- fwd_valid  out  1  forwarding tap valid.
- fwd_rd  out  5  forwarding tap register.
- fwd_data  out  XLEN  forwarding tap data.
- load_misaligned  out  1  one-cycle pulse when a misaligned load retires.
- retire_count  out  RET_W  instructions retired since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid_q=0 and all captured fields 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, load_misaligned=0, retire_count=0.
  - in_ready=1 once reset is released.
  - Reset mid-operation discards the held entry; no write is issued.
- Holding register:
  - Single entry. in_ready = !valid_q || rf_ready (combinational).
  - Capture on edge when in_valid && in_ready && !flush.
- Retire: an entry retires on an edge where valid_q && rf_ready.
  - If a new capture coincides with a retire, the new entry replaces the old one (back-to-back throughput of 1/cycle).
  - If retiring with no capture, valid_q goes to 0.
- Stall: while valid_q && !rf_ready, all captured fields hold and in_ready=0. Upstream must keep its inputs stable.
- Flush:
  - valid_q goes to 0 next edge; the incoming entry that cycle is not captured.
  - Flush has priority over capture and retire. A held entry seeing flush and rf_ready together does not retire and does not count.
- Outputs are combinational from the registers (latency: capture edge to rf_we is 0 further cycles).
  - rf_we = valid_q && reg_write_q && rd_q!=0 && rf_ready && !misaligned && !flush.
  - rf_waddr = rd_q; rf_wdata = selected value.
  - fwd_valid = valid_q && reg_write_q && rd_q!=0 && !misaligned. This is independent of rf_ready, so stalled data still forwards.
  - fwd_rd = rd_q; fwd_data = rf_wdata.
- Load alignment (wb_sel=01), little-endian, byte offset = aluout_q[1:0]:
  - 000 lb: byte sign-extended.
  - 100 lbu: byte zero-extended.
  - 001 lh: halfword at offset[1]*16, sign-extended.
  - 101 lhu: same halfword, zero-extended.
  - 010 lw and any other code: full word.
- Misaligned:
  - Defined as lh/lhu with offset[0]=1, or lw with offset!=0.
  - Suppresses rf_we and fwd_valid.
  - load_misaligned is a registered pulse: high for exactly one cycle after the retire edge.
  - Still counts as retired.
- retire_count: increments by 1 per retire, wraps from all-ones to 0. rd=0 or reg_write=0 instructions still count.

Decomposition:
- Shared package core_pkg:
  - wb_sel_e enum (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10).
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN default.
- One combinational sub-module load_align.
  - Inputs: word, offset, funct3.
  - Outputs: aligned data and misaligned flag.
  - Reused later by a store-side byte-enable generator.

Test Plan:
- Reset then capture ALU op: aluout=0x0000_1234, rd=5, reg_write=1, wb_sel=00, rf_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234; retire_count=1 after edge.
- Sub-word loads, read_data=0x8081_F2A3:
  - lb offset 0 -> 0xFFFF_FFA3.
  - lbu offset 1 -> 0x0000_00F2.
  - lh offset 2 -> 0xFFFF_8081.
  - lhu offset 0 -> 0x0000_F2A3.
- Misaligned load: lw at aluout=0x102 -> rf_we=0, fwd_valid=0; load_misaligned=1 for exactly one cycle after the retire edge; retire_count increments.
- Stall: entry held and rf_ready=0 for 3 cycles -> in_ready=0, rf_we=0, fwd_valid=1 with stable data. rf_ready=1 -> single write, and the new entry is captured on the same edge.
- Flush while held and rf_ready=1 with in_valid=1 -> no write, no count, valid_q=0, incoming entry dropped.
- Boundaries:
  - rd=0 with reg_write=1 -> rf_we=0, count increments.
  - retire_count preloaded near wrap (RET_W=4, 15 retires then one more) -> reads 0.
  - rst_n asserted mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: writeback source select, load funct3 codes, datapath width.
package core_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Little-endian sub-word load extraction and alignment check.
// Shared with the store side, so it knows nothing about pipeline state.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    assign shifted = word >> {offset, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_v};
                misaligned = offset[0];
            end
            F3_LW:   misaligned = (offset != 2'b00);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB holding register and writeback select. One entry, valid/ready toward
// the memory stage, register-file write plus a forwarding tap that ignores stalls.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [XLEN-1:0]  aluout,
    input  logic [XLEN-1:0]  read_data,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [4:0]       rd,
    input  logic             reg_write,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       load_f3,
    input  logic             rf_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             load_misaligned,
    output logic [RET_W-1:0] retire_count
);

    logic             valid_q;
    logic [XLEN-1:0]  aluout_q;
    logic [XLEN-1:0]  read_data_q;
    logic [XLEN-1:0]  pc_plus4_q;
    logic [4:0]       rd_q;
    logic             reg_write_q;
    logic [1:0]       wb_sel_q;
    logic [2:0]       load_f3_q;
    logic             mis_pulse_q;
    logic [RET_W-1:0] retire_q;

    logic             capture;
    logic             retire;
    logic [XLEN-1:0]  load_data;
    logic             align_mis;
    logic             misaligned;
    logic             writes_rd;
    logic [XLEN-1:0]  wb_data;

    // Flush outranks both: a held entry seeing flush neither writes nor counts.
    assign in_ready = !valid_q || rf_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign retire   = valid_q && rf_ready && !flush;

    load_align #(.XLEN(XLEN)) u_align (
        .word       (read_data_q),
        .offset     (aluout_q[1:0]),
        .funct3     (load_f3_q),
        .data       (load_data),
        .misaligned (align_mis)
    );

    // Only a real load can be misaligned; aluout is arbitrary for ALU ops.
    assign misaligned = (wb_sel_q == WB_MEM) && align_mis;

    always_comb begin
        wb_data = aluout_q;
        case (wb_sel_q)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = pc_plus4_q;
            default: wb_data = aluout_q;
        endcase
    end

    assign writes_rd = valid_q && reg_write_q && (rd_q != 5'd0) && !misaligned;

    assign rf_we           = writes_rd && rf_ready && !flush;
    assign rf_waddr        = rd_q;
    assign rf_wdata        = wb_data;
    assign fwd_valid       = writes_rd;
    assign fwd_rd          = rd_q;
    assign fwd_data        = wb_data;
    assign load_misaligned = mis_pulse_q;
    assign retire_count    = retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (retire) begin
            valid_q <= 1'b0;
        end
    end

    // Fields only move on capture, so a stalled entry stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_q    <= '0;
            read_data_q <= '0;
            pc_plus4_q  <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= '0;
            load_f3_q   <= '0;
        end else if (capture) begin
            aluout_q    <= aluout;
            read_data_q <= read_data;
            pc_plus4_q  <= pc_plus4;
            rd_q        <= rd;
            reg_write_q <= reg_write;
            wb_sel_q    <= wb_sel;
            load_f3_q   <= load_f3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_pulse_q <= 1'b0;
            retire_q    <= '0;
        end else begin
            mis_pulse_q <= retire && misaligned;
            if (retire) begin
                retire_q <= retire_q + RET_W'(1);
            end
        end
    end

endmodule
